// File: rtl/capture_pkg.sv
// capture_pkg: shared types and helpers for the capture controller.
//   state_t           - controller FSM states
//   calc_play_period  - clock cycles per playback word from word length,
//                       system clock and PDM sample frequencies
package capture_pkg;

  localparam longint CLK_HZ    = 100_000_000;
  localparam longint SAMPLE_HZ = 1_000_000;

  typedef enum logic [2:0] {
    IDLE,
    RECORD,
    PLAY_REQ,
    PLAY_OUT,
    PLAY_WAIT
  } state_t;

  // One word takes word_len PDM samples; each sample lasts clk/sample cycles.
  function automatic int calc_play_period(input int word_len, input longint clk_hz,
                                          input longint sample_hz);
    return int'(longint'(word_len) * clk_hz / sample_hz);
  endfunction

endpackage

// File: rtl/capture_controller_period_counter.sv
// period_counter: loadable down-counter used to pace playback words.
//   clock_i, reset_i  - system clock, synchronous active-high reset
//   load_i            - load load_value_i (wins over enable_i)
//   load_value_i      - value to load
//   enable_i          - count down by one per cycle, saturating at 0
//   expired_o         - count is zero
module period_counter #(
  parameter int W = 11
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         enable_i,
  output logic         expired_o
);

  logic [W-1:0] count;

  always_ff @(posedge clock_i) begin
    if (reset_i)                         count <= '0;
    else if (load_i)                     count <= load_value_i;
    else if (enable_i && count != '0)    count <= count - 1'b1;
  end

  assign expired_o = (count == '0);

endmodule

// File: rtl/capture_controller.sv
// capture_controller: record/playback sequencer between the PDM deserializer
// and a single-port synchronous audio buffer RAM.
//   clock_i, reset_i        - system clock, synchronous active-high reset
//   record_i, play_i        - debounced buttons (hold to record, rise to play)
//   deser_enable_o          - deserializer enable (high only while recording)
//   deser_done_i/data_i     - completed deserializer word strobe and data
//   mem_we_o/addr_o/wdata_o - RAM write strobe, address, write data
//   mem_rdata_i             - RAM read data, one cycle after address
//   audio_data_o/valid_o    - playback word and its update strobe
//   word_count_o            - words in the last recording
//   busy_o                  - controller not idle
module capture_controller
  import capture_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 17,
  parameter int PLAY_PERIOD = calc_play_period(16, CLK_HZ, SAMPLE_HZ)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   record_i,
  input  logic                   play_i,
  output logic                   deser_enable_o,
  input  logic                   deser_done_i,
  input  logic [WORD_LENGTH-1:0] deser_data_i,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [WORD_LENGTH-1:0] mem_wdata_o,
  input  logic [WORD_LENGTH-1:0] mem_rdata_i,
  output logic [WORD_LENGTH-1:0] audio_data_o,
  output logic                   audio_valid_o,
  output logic [ADDR_WIDTH:0]    word_count_o,
  output logic                   busy_o
);

  localparam int CW = (PLAY_PERIOD > 2) ? $clog2(PLAY_PERIOD) : 1;
  // PLAY_OUT + PLAY_REQ take two of the period's cycles; the counter covers
  // the rest, expiring on its last PLAY_WAIT cycle.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(PLAY_PERIOD - 3);
  localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  rearm;
  logic                  play_d;
  logic                  play_rise;
  logic                  cnt_expired;

  assign play_rise      = play_i && !play_d;
  assign deser_enable_o = (state == RECORD);
  assign busy_o         = (state != IDLE);

  period_counter #(.W(CW)) u_period (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (state == PLAY_OUT),
    .load_value_i (WAIT_LOAD),
    .enable_i     (state == PLAY_WAIT),
    .expired_o    (cnt_expired)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rearm         <= 1'b0;
      play_d        <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      audio_data_o  <= '0;
      audio_valid_o <= 1'b0;
      word_count_o  <= '0;
    end else begin
      play_d        <= play_i;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      audio_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!record_i) rearm <= 1'b0;
          if (record_i && !rearm) begin
            state        <= RECORD;
            wr_ptr       <= '0;
            word_count_o <= '0;
          end else if (play_rise && word_count_o != '0) begin
            state      <= PLAY_REQ;
            rd_ptr     <= '0;
            mem_addr_o <= '0;
          end
        end
        RECORD: begin
          // The write is issued in the cycle after done, so leaving here on
          // the same edge never drops a registered word.
          if (deser_done_i) begin
            mem_we_o     <= 1'b1;
            mem_addr_o   <= wr_ptr;
            mem_wdata_o  <= deser_data_i;
            wr_ptr       <= wr_ptr + 1'b1;
            word_count_o <= word_count_o + 1'b1;
          end
          if (deser_done_i && word_count_o == LAST_WORD) begin
            state <= IDLE;
            rearm <= 1'b1;   // buffer full: wait for button release
          end else if (!record_i) begin
            state <= IDLE;
          end
        end
        PLAY_REQ: state <= PLAY_OUT;
        PLAY_OUT: begin
          audio_data_o  <= mem_rdata_i;
          audio_valid_o <= 1'b1;
          rd_ptr        <= rd_ptr + 1'b1;
          state         <= (rd_ptr + 1'b1 == word_count_o) ? IDLE : PLAY_WAIT;
        end
        PLAY_WAIT: begin
          if (cnt_expired) begin
            state      <= PLAY_REQ;
            mem_addr_o <= rd_ptr[ADDR_WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;

  localparam int WL = 16;
  localparam int AW = 3;
  localparam int PP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          record, play;
  logic          deser_en, deser_done;
  logic [WL-1:0] deser_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WL-1:0] mem_wdata, mem_rdata;
  logic [WL-1:0] audio_data;
  logic          audio_valid;
  logic [AW:0]   word_count;
  logic          busy;

  logic [WL-1:0] ram [0:(1<<AW)-1];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  capture_controller #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .PLAY_PERIOD(PP)) dut (
    .clock_i(clk), .reset_i(rst), .record_i(record), .play_i(play),
    .deser_enable_o(deser_en), .deser_done_i(deser_done), .deser_data_i(deser_data),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .audio_data_o(audio_data), .audio_valid_o(audio_valid),
    .word_count_o(word_count), .busy_o(busy)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; record = 1'b0; play = 1'b0; deser_done = 1'b0; deser_data = '0;
    step(); step();
    total++;
    if ({deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy});
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (deser_en !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL idle_quiet cyc%0d: en=%b busy=%b we=%b want 0 0 0", i, deser_en, busy, mem_we);
      else passed++;
    end
  endtask

  task automatic test_short_record();
    logic [WL-1:0] d [3];
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
    record = 1'b1;
    step();
    total++;
    if (busy !== 1'b1 || deser_en !== 1'b1)
      $display("FAIL rec_enter: busy=%b en=%b want 1 1", busy, deser_en);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      deser_data = d[i]; deser_done = 1'b1;
      step();
      deser_done = 1'b0;
      total++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== d[i] || word_count !== (AW+1)'(i+1))
        $display("FAIL rec_write%0d: we=%b addr=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                 i, mem_we, mem_addr, mem_wdata, word_count, i, d[i], i+1);
      else passed++;
      step();
      total++;
      if (mem_we !== 1'b0) $display("FAIL rec_we_pulse%0d: we=%b want 0", i, mem_we);
      else passed++;
    end
    record = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || deser_en !== 1'b0 || word_count !== 4'd3)
      $display("FAIL rec_exit: busy=%b en=%b cnt=%0d want 0 0 3", busy, deser_en, word_count);
    else passed++;
  endtask

  task automatic test_playback();
    logic [WL-1:0] d [3];
    int pulses = 0;
    int last = 0;
    int we_seen = 0;
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
    play = 1'b1;
    step();
    play = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL play_start: busy=%b want 1", busy);
    else passed++;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (mem_we) we_seen++;
      if (audio_valid) begin
        total++;
        if (pulses < 3 && audio_data === d[pulses] && (c - last) == ((pulses == 0) ? 2 : PP))
          passed++;
        else
          $display("FAIL play_word%0d: data=%h gap=%0d want %h gap=%0d", pulses, audio_data,
                   c - last, (pulses < 3) ? d[pulses] : 16'h0, (pulses == 0) ? 2 : PP);
        if (pulses == 2) begin
          total++;
          if (busy !== 1'b0) $display("FAIL play_end_idle: busy=%b want 0", busy);
          else passed++;
        end
        pulses++;
        last = c;
      end
    end
    total++;
    if (pulses != 3 || we_seen != 0)
      $display("FAIL play_count: pulses=%0d writes=%0d want 3 0", pulses, we_seen);
    else passed++;
  endtask

  task automatic test_full_buffer();
    int writes = 0;
    record = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      deser_data = WL'(16'hA000 + i); deser_done = 1'b1;
      step();
      deser_done = 1'b0;
      if (mem_we) begin
        total++;
        if (mem_addr !== AW'(i) || mem_wdata !== WL'(16'hA000 + i))
          $display("FAIL full_write%0d: addr=%0d data=%h want %0d %h", i, mem_addr, mem_wdata,
                   i, 16'hA000 + i);
        else passed++;
        writes++;
      end
      if (i == 7) begin
        total++;
        if (deser_en !== 1'b0 || busy !== 1'b0 || word_count !== 4'd8)
          $display("FAIL full_stop: en=%b busy=%b cnt=%0d want 0 0 8", deser_en, busy, word_count);
        else passed++;
      end
      step();
      if (mem_we) writes++;
    end
    total++;
    if (writes != 8 || word_count !== 4'd8)
      $display("FAIL full_writes: writes=%0d cnt=%0d want 8 8", writes, word_count);
    else passed++;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (busy !== 1'b0 || deser_en !== 1'b0 || word_count !== 4'd8)
      $display("FAIL full_hold: busy=%b en=%b cnt=%0d want 0 0 8", busy, deser_en, word_count);
    else passed++;
    record = 1'b0;
    step();
    record = 1'b1;
    step();
    total++;
    if (busy !== 1'b1 || deser_en !== 1'b1 || word_count !== 4'd0)
      $display("FAIL full_rearm: busy=%b en=%b cnt=%0d want 1 1 0", busy, deser_en, word_count);
    else passed++;
    record = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    // Give the recording content so play would be honoured if not overridden.
    record = 1'b1; step();
    deser_data = 16'h7777; deser_done = 1'b1; step(); deser_done = 1'b0;
    record = 1'b0; step(); step();
    record = 1'b1; play = 1'b1;
    step();
    total++;
    if (deser_en !== 1'b1 || busy !== 1'b1 || word_count !== 4'd0)
      $display("FAIL simul_record: en=%b busy=%b cnt=%0d want 1 1 0", deser_en, busy, word_count);
    else passed++;
    record = 1'b0; play = 1'b0;
    step(); step();
    play = 1'b1;
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL play_empty_busy: busy=%b want 0", busy);
    else passed++;
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (audio_valid) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL play_empty: pulses=%0d want 0", pulses);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int writes = 0;
    record = 1'b1; step();
    deser_data = 16'h5555; deser_done = 1'b1; step(); deser_done = 1'b0; step();
    deser_data = 16'h6666; deser_done = 1'b1; step(); deser_done = 1'b0; step();
    record = 1'b0; step();
    play = 1'b1; step(); play = 1'b0;
    while (!audio_valid && guard < 20) begin step(); guard++; end
    total++;
    if (!audio_valid || audio_data !== 16'h5555)
      $display("FAIL mid_play_word: valid=%b data=%h want 1 5555", audio_valid, audio_data);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy} !== '0)
      $display("FAIL reset_in_wait: got %h want 0",
               {deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy});
    else passed++;
    record = 1'b1; step();
    deser_data = 16'h9999; deser_done = 1'b1; step();
    total++;
    if (mem_we !== 1'b1) $display("FAIL pre_reset_write: we=%b want 1", mem_we);
    else passed++;
    // A second word arrives together with reset: it must not be written.
    deser_data = 16'h8888; rst = 1'b1; record = 1'b0;
    step();
    deser_done = 1'b0; rst = 1'b0;
    total++;
    if ({deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy} !== '0)
      $display("FAIL reset_in_write: got %h want 0",
               {deser_en, mem_we, mem_addr, mem_wdata, audio_data, audio_valid, word_count, busy});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_we) writes++;
    end
    total++;
    if (writes != 0 || word_count !== 4'd0)
      $display("FAIL post_reset_quiet: writes=%0d cnt=%0d want 0 0", writes, word_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_short_record();
    test_playback();
    test_full_buffer();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
